// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the alu_share_arb slice: ALU opcode encodings, the
// arbiter FSM state encoding and the opcode legality helper.
// Optional feature macro used by importers: ALU_OPCHK_EN.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for the opcodes the shared ALU actually implements.
    function automatic logic op_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at index ptr and
// wraps modulo NREQ; the first asserted request wins. The pointer register is
// owned by the parent.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IDW   first index to consider
//   gnt     out NREQ  one-hot grant (zero when no request)
//   gnt_idx out IDW   index of the granted requester (0 when none)
//   any     out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Rotating priority search starting at ptr.
    always_comb begin
        int             idx_v;
        logic [IDW-1:0] idx_b;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx_v   = 0;
        idx_b   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(ptr) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            idx_b = IDW'(idx_v);
            if (!any && req[idx_b]) begin
                any        = 1'b1;
                gnt[idx_b] = 1'b1;
                gnt_idx    = idx_b;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
// Time-shares one combinational ALU among NREQ requesters. A round-robin grant
// in IDLE accepts one request, its operands sit on alu_* for the single EXEC
// cycle, and the captured result is returned in RESP tagged with the
// requester index. One operation completes at most every three cycles.
// Optional feature macro: ALU_OPCHK_EN -- when defined, illegal opcodes are not
// sent to the ALU and come back as rsp_err=1 with a zero result; otherwise all
// opcodes are forwarded and rsp_err is tied low.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_op       packed per-requester operands, slot i at [i*W +: W]
//   alu_a/alu_b/alu_op       registered operands to the shared ALU
//   alu_z/alu_ex             ALU result and zero/exception flag
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_z/rsp_ex/rsp_err  response payload
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [2:0]      alu_op,
    input  logic [W-1:0]    alu_z,
    input  logic            alu_ex,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_z,
    output logic            rsp_ex,
    output logic            rsp_err
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic            any_s;
    logic            hs_s;
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic [2:0]      sel_op_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign sel_a_s  = req_a[gnt_idx_s*W +: W];
    assign sel_b_s  = req_b[gnt_idx_s*W +: W];
    assign sel_op_s = req_op[gnt_idx_s*3 +: 3];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; RESP always returns to IDLE before a new grant.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: grant visible only in IDLE and never while reset is held,
    // so any request the winner presents in IDLE is an accepted handshake.
    always_comb begin
        req_ready = '0;
        hs_s      = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            req_ready = gnt_s;
            hs_s      = any_s;
        end else begin
            req_ready = '0;
            hs_s      = 1'b0;
        end
    end

    // Round-robin pointer: moves only on an accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (hs_s) begin
            if (gnt_idx_s == IDW'(NREQ - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= gnt_idx_s + IDW'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

`ifdef ALU_OPCHK_EN
    logic err_r;
    logic rsp_err_r;

    // Operand capture at grant; illegal opcodes leave the ALU inputs untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r   <= '0;
            err_r  <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 3'b000;
        end else if (hs_s) begin
            id_r  <= gnt_idx_s;
            err_r <= !op_legal(sel_op_s);
            if (op_legal(sel_op_s)) begin
                alu_a  <= sel_a_s;
                alu_b  <= sel_b_s;
                alu_op <= sel_op_s;
            end else begin
                alu_a  <= alu_a;
                alu_b  <= alu_b;
                alu_op <= alu_op;
            end
        end else begin
            id_r   <= id_r;
            err_r  <= err_r;
            alu_a  <= alu_a;
            alu_b  <= alu_b;
            alu_op <= alu_op;
        end
    end

    // Response capture at the end of EXEC; errored ops return a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_ex    <= 1'b0;
            rsp_err_r <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_z     <= err_r ? '0 : alu_z;
            rsp_ex    <= err_r ? 1'b0 : alu_ex;
            rsp_err_r <= err_r;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    // Operand capture at grant; every opcode is forwarded to the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r   <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 3'b000;
        end else if (hs_s) begin
            id_r   <= gnt_idx_s;
            alu_a  <= sel_a_s;
            alu_b  <= sel_b_s;
            alu_op <= sel_op_s;
        end else begin
            id_r   <= id_r;
            alu_a  <= alu_a;
            alu_b  <= alu_b;
            alu_op <= alu_op;
        end
    end

    // Response capture at the end of EXEC, held until the consumer accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_ex    <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_z     <= alu_z;
            rsp_ex    <= alu_ex;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= rsp_valid;
        end
    end

    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
// Directed, table-driven bench for alu_share_arb with a behavioural model of
// the shared ALU (opcode 011 is given an XOR behaviour so pass-through of an
// unchecked opcode is observable). Expectations follow ALU_OPCHK_EN.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [2:0]        alu_op;
    logic [W-1:0]      alu_z;
    logic              alu_ex;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_z;
    logic              rsp_ex;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;

    alu_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_ex    (alu_ex),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ex    (rsp_ex),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Shared ALU model.
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b011:  alu_z = alu_a ^ alu_b;
            default: alu_z = 32'd0;
        endcase
        alu_ex = (alu_z == 32'd0);
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        bad;
        logic [31:0] z;
        logic        ex;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[idx*W +: W]  = a;
        req_b[idx*W +: W]  = b;
        req_op[idx*3 +: 3] = op;
    endtask

    // Waits (bounded) for a grant, checks it is the expected one-hot, then
    // steps to just after the accepting edge (DUT now in EXEC).
    task automatic wait_grant(input int idx, input string nm);
        int              cyc;
        logic [NREQ-1:0] exp_g;
        exp_g      = '0;
        exp_g[idx] = 1'b1;
        cyc        = 0;
        @(negedge clk);
        while (req_ready == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_grant"}, 64'(req_ready), 64'(exp_g));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] last_a;
    logic [2:0]  last_op;
    logic [31:0] exp_a;
    logic [2:0]  exp_op;

    initial begin
        vec_t v;
        // idx  a             b             op      bad  z             ex    err
        vecs[0] = '{2, 32'd7,        32'd5,        3'b010, 1'b0, 32'd12,       1'b0, 1'b0};
        vecs[1] = '{0, 32'hFFFFFFFF, 32'd1,        3'b010, 1'b0, 32'd0,        1'b1, 1'b0};
        vecs[2] = '{3, 32'hF0F000FF, 32'h0FF00F0F, 3'b000, 1'b0, 32'h00F0000F, 1'b0, 1'b0};
        vecs[3] = '{1, 32'hF0000000, 32'h0000000F, 3'b001, 1'b0, 32'hF000000F, 1'b0, 1'b0};
        vecs[4] = '{2, 32'd5,        32'd7,        3'b110, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{3, 32'hFFFFFFFF, 32'd1,        3'b111, 1'b0, 32'd1,        1'b0, 1'b0};
        vecs[6] = '{0, 32'd1,        32'hFFFFFFFF, 3'b111, 1'b0, 32'd0,        1'b1, 1'b0};
`ifdef ALU_OPCHK_EN
        vecs[7] = '{1, 32'h12345678, 32'h0000FFFF, 3'b011, 1'b1, 32'd0,        1'b0, 1'b1};
`else
        vecs[7] = '{1, 32'h12345678, 32'h0000FFFF, 3'b011, 1'b1, 32'h1234A987, 1'b0, 1'b0};
`endif

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        last_a    = 32'd0;
        last_op   = 3'b000;

        // Reset values, with a request present to show ready is held low.
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_z",     64'(rsp_z),     64'd0);
        chk("rst_alu_op",    64'(alu_op),    64'd0);
        chk("rst_alu_a",     64'(alu_a),     64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven single operations, rsp_ready held high.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            set_req(v.idx, v.a, v.b, v.op);
            req_valid[v.idx] = 1'b1;
            wait_grant(v.idx, $sformatf("tbl%0d", i));
            req_valid = '0;
`ifdef ALU_OPCHK_EN
            exp_a  = v.bad ? last_a  : v.a;
            exp_op = v.bad ? last_op : v.op;
`else
            exp_a  = v.a;
            exp_op = v.op;
`endif
            last_a  = exp_a;
            last_op = exp_op;
            @(negedge clk);
            chk($sformatf("tbl%0d_exec_alu_op", i), 64'(alu_op), 64'(exp_op));
            chk($sformatf("tbl%0d_exec_alu_a", i),  64'(alu_a),  64'(exp_a));
            chk($sformatf("tbl%0d_exec_rsp_valid", i), 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("tbl%0d_rsp_id", i),    64'(rsp_id),    64'(v.idx));
            chk($sformatf("tbl%0d_rsp_z", i),     64'(rsp_z),     64'(v.z));
            chk($sformatf("tbl%0d_rsp_ex", i),    64'(rsp_ex),    64'(v.ex));
            chk($sformatf("tbl%0d_rsp_err", i),   64'(rsp_err),   64'(v.err));
            @(posedge clk);
            #1;
        end

        // Reset in RESP: requester 1 moves the pointer to 2, then reset.
        rsp_ready = 1'b0;
        set_req(1, 32'd1, 32'd1, 3'b010);
        req_valid[1] = 1'b1;
        wait_grant(1, "rstmid");
        req_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_pre_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'h11111111 * (i + 1), 32'hFFFFFFFF, 3'b000);
        end
        req_valid = 4'b1001;
        #1;
        chk("rstmid_resp_ready_low", 64'(req_ready), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_req_ready", 64'(req_ready), 64'd0);
        chk("rstmid_rsp_z",     64'(rsp_z),     64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;

        // Round robin with every requester valid: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NREQ;
            wait_grant(e, $sformatf("rr%0d", k));
            @(negedge clk);
            chk($sformatf("rr%0d_exec_ready", k), 64'(req_ready), 64'd0);
            chk($sformatf("rr%0d_exec_alu_a", k), 64'(alu_a), 64'(32'h11111111 * (e + 1)));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("rr%0d_rsp_ready_low", k), 64'(req_ready), 64'd0);
            chk($sformatf("rr%0d_rsp_id", k), 64'(rsp_id), 64'(e));
            chk($sformatf("rr%0d_rsp_z", k),  64'(rsp_z),  64'(32'h11111111 * (e + 1)));
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        // Backpressure: SUB 3-3 held for five cycles while requester 2 waits.
        rsp_ready = 1'b0;
        set_req(1, 32'd3, 32'd3, 3'b110);
        req_valid[1] = 1'b1;
        wait_grant(1, "bp");
        req_valid = '0;
        set_req(2, 32'd10, 32'd20, 3'b010);
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp%0d_rsp_z", c),     64'(rsp_z),     64'd0);
            chk($sformatf("bp%0d_rsp_ex", c),    64'(rsp_ex),    64'd1);
            chk($sformatf("bp%0d_rsp_id", c),    64'(rsp_id),    64'd1);
            chk($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_no_same_cycle_grant", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp_next_grant",      64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_next_rsp_id", 64'(rsp_id), 64'd2);
        chk("bp_next_rsp_z",  64'(rsp_z),  64'd30);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Time-shares one combinational 32-bit ALU (yAlu-compatible: `z`, `ex`, `a`, `b`, 3-bit `op`) among NREQ requesters.
- Each requester uses a valid/ready handshake.
- A round-robin grant picks one request. Operands are registered into the ALU for one cycle, and the result is captured and returned tagged with the requester ID.
- Sits between issuing units and the shared yAlu instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, operand/result width
- IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*W  packed operand A, requester i at [i*W +: W]
- req_b  in  NREQ*W  packed operand B
- req_op  in  NREQ*3  packed opcode
- alu_a  out  W  operand A to shared ALU
- alu_b  out  W  operand B to shared ALU
- alu_op  out  3  opcode to shared ALU
- alu_z  in  W  ALU result (combinational)
- alu_ex  in  1  ALU zero/exception flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of requester that issued the operation
- rsp_z  out  W  captured result
- rsp_ex  out  1  captured ALU flag
- rsp_err  out  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset values, asynchronous:
  - state=IDLE, rr_ptr=0
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ex=0, rsp_err=0
  - alu_a/alu_b=0, alu_op=3'b000
- IDLE state:
  - Round-robin search starts at rr_ptr; the first i with req_valid[i]=1 wins.
  - req_ready[i] is asserted combinationally in IDLE for the winner only.
  - Handshake completes when req_valid[i] and req_ready[i] are both high.
  - On handshake: latch a/b/op/id into operand registers, set rr_ptr=(i+1) mod NREQ, go to EXEC.
- EXEC state (exactly 1 cycle):
  - alu_a/alu_b/alu_op are driven from the operand registers.
  - At the clock edge, rsp_z<=alu_z, rsp_ex<=alu_ex, rsp_id<=id, rsp_valid<=1; go to RESP.
- RESP state:
  - Hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid and go to IDLE. No new grant is issued in this same cycle.
- Latency: accept at cycle N, rsp_valid high from cycle N+2. Throughput is one operation per 3 cycles minimum.
- req_ready is 0 in EXEC and RESP. At most one bit of req_ready is ever set.
- rr_ptr wraps from NREQ-1 to 0. It changes only on an accepted grant, so a requester that drops valid before being granted does not move the pointer.
- Outside EXEC, alu_* hold their last value and do not toggle.
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT are legal.
  - Width is W; results wrap modulo 2^W.
  - No carry or overflow is reported beyond alu_ex.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is produced.
- If rsp_valid and rsp_ready rise in the same cycle that a new request is valid, the new request is granted in the next cycle (IDLE).

Optional Feature:
- Macro: ALU_OPCHK_EN.
- Defined:
  - At grant, an opcode outside {000,001,010,110,111} sets an err bit.
  - EXEC does not drive alu_* (they hold their previous value).
  - The response returns rsp_z=0, rsp_ex=0, rsp_err=1.
  - Latency is unchanged.
- Undefined:
  - All opcodes are forwarded to the ALU unchanged.
  - rsp_err is tied to 0.

Decomposition:
- Package alu_arb_pkg:
  - opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - function op_legal(op)
- Sub-module rr_arbiter: NREQ-wide round-robin grant.
  - Inputs: req, ptr.
  - Outputs: onehot gnt, gnt_idx, any.
  - Purely combinational.
  - The pointer register stays in the parent.

Test Plan:
1. Reset test:
   - Assert rst mid-RESP with rsp_valid=1.
   - Required: rsp_valid=0 and req_ready=0 immediately (asynchronous); after release, first grant goes to requester 0.
2. Single op:
   - Req 2 only: a=7, b=5, op=010, rsp_ready=1.
   - Required: req_ready[2] at cycle N; rsp_valid at N+2 with rsp_id=2, rsp_z=12, rsp_ex=0.
3. Round robin:
   - All 4 requesters hold valid with op=000.
   - Required: grant order 0,1,2,3,0; each rsp_id matches.
4. Backpressure:
   - rsp_ready=0 for 5 cycles after a SUB with a=3, b=3.
   - Required: rsp_z=0 and rsp_ex=1 held stable; req_ready all 0 throughout; the next grant comes only after rsp_ready=1.
5. Wrap-around arithmetic:
   - a=32'hFFFFFFFF, b=1, op=010.
   - Required: rsp_z=0, rsp_ex=1 (ALU zero flag).
6. Illegal opcode (ALU_OPCHK_EN defined):
   - op=011.
   - Required: rsp_err=1, rsp_z=0, alu_op unchanged during EXEC.
   - Without the macro: rsp_err=0 and the ALU output is passed through.
